cp0_exc_ctrl: RTL
=================

// Module: cp0_exc_ctrl
// PURPOSE
//  Exception/interrupt controller; the initiator that drives cp0_reg's write port.
//  Sits beside the MEM stage. Inputs: MEM-stage exception flags plus current Status/Cause/EPC.
//  Decides the exception to take, then flushes the pipeline and redirects the PC.
//  Then sequences the EPC, Status and Cause writes into cp0_reg, one write per cycle.
// PARAMETERS
//  EXC_VECTOR   32'h0000_0020  PC loaded on exception entry
//  IP_WIDTH     8              interrupt-pending bits examined, Cause/Status[15:8]
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous reset, active-high
//  mem_valid_i     in   1   MEM-stage instruction valid (pc != 0)
//  mem_exc_i       in   5   {trap, ov, ri, syscall, eret} flags from MEM
//  mem_pc_i        in   32  MEM-stage instruction PC
//  mem_in_ds_i     in   1   MEM instruction sits in a branch delay slot
//  wb_cp0_we_i     in   1   in-flight mtc0 write (bypass)
//  wb_cp0_waddr_i  in   5   in-flight mtc0 address
//  wb_cp0_data_i   in   32  in-flight mtc0 data
//  status_i        in   32  cp0 Status
//  cause_i         in   32  cp0 Cause
//  epc_i           in   32  cp0 EPC
//  cp0_we_o        out  1   write strobe to cp0
//  cp0_waddr_o     out  5   write address
//  cp0_data_o      out  32  write data
//  cp0_exc_o       out  1   exception-class write: cp0 accepts all Cause bits
//  flush_o         out  1   one-cycle pipeline flush
//  new_pc_o        out  32  redirect target, valid while flush_o
//  stall_req_o     out  1   hold IF..MEM while the sequence runs
//  excode_o        out  5   ExcCode of the exception being taken (debug/trace)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; latched pc/code/bd cleared.
//  - Effective Status/Cause: the cp0 value, overridden by wb_cp0_* on an address match.
//    Cause keeps only the mtc0-writable bits [9:8].
//  - Interrupt pending: |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL & mem_valid_i.
//  - Priority (high to low) and ExcCode:
//    Int 0x00 > Sys 0x08 > RI 0x0a > Ov 0x0c > Tr 0x0d > eret.
//  - IDLE, exception at cycle N: latch the code.
//    Latch EPC = in_ds ? pc-4 : pc, and BD = in_ds.
//  - N+1 (FLUSH): flush_o=1, new_pc_o=EXC_VECTOR, stall_req_o=1, state W_EPC.
//    Also writes EPC: cp0_we_o=1, waddr=EPC, cp0_exc_o=1.
//  - N+2 (W_STATUS): write Status = effective Status with EXL=1.
//  - N+3 (W_CAUSE): write Cause = effective Cause with [31]=BD and [6:2]=ExcCode.
//    IP bits are passed through unchanged. Return to IDLE; stall_req_o drops at N+4.
//  - eret in IDLE: FLUSH with new_pc_o = epc_i, or wb_cp0_data_i on an EPC-address bypass.
//    Next cycle: write Status with EXL=0, then IDLE. Total 2 busy cycles.
//  - No new exception is sampled outside IDLE; mem_* inputs are ignored while busy.
//  - If EXL=1 at detection: synchronous exceptions still update Cause.
//    In that case EPC is NOT rewritten (state W_EPC skipped, no write strobe).
//  - Exceptions flagged with mem_valid_i=0 are ignored.
//  - rst mid-sequence: return to IDLE in the same cycle.
//    Partially written CP0 state is left as written; cp0 resets too.
// CONFIGURATION
//  CP0_EXC_BADVADDR_EN defined:
//  - Adds inputs mem_addr_i[31:0], mem_ld_i and mem_st_i, and output badvaddr_o[31:0].
//  - Misaligned access raises AdEL 0x04 (load) or AdES 0x05 (store).
//    Priority is between Int and Sys.
//  - badvaddr_o loads mem_addr_i at FLUSH. Reset value 0.
//  Undefined: those ports and the AdEL/AdES exceptions are absent.
// STRUCTURE
//  - defines.v holds the shared constants:
//    EXC_* codes, CP0_REG_* addresses, Status EXL/IE bit indices, FSM state encodings.
//  - Sub-module exc_prio_enc: combinational flag vector in, {valid, excode} out.
//  - FSM, latches and write mux live in cp0_exc_ctrl.
// TESTING
//  - Status=0x1000_0401, cause_i IP2 set, pc=0x100 -> flush at N+1 to 0x20.
//    EPC write 0x100; Status write 0x1000_0403; Cause ExcCode 0.
//  - syscall with in_ds=1, pc=0x208 -> EPC=0x204, Cause[31]=1, ExcCode 0x08.
//    stall_req_o high for exactly 3 cycles.
//  - eret, epc_i=0x300, Status EXL=1 -> flush, new_pc 0x300; next cycle Status write with EXL=0.
//  - ov and ri together -> ExcCode 0x0a. Interrupt with Status.IE=0 -> no flush.
//  - In-flight mtc0 EPC=0x440 in the same cycle as eret -> new_pc_o=0x440.
//    A second syscall during the sequence is ignored.
//  - rst asserted at N+2 -> outputs 0 next cycle, FSM IDLE.
//    With CP0_EXC_BADVADDR_EN: load at addr 0x1001 -> ExcCode 0x04, badvaddr_o=0x1001.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception controller: ExcCodes, CP0 register addresses,
// Status bit indices, priority-flag layout and FSM state encodings.
package cp0_exc_ctrl_pkg;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;
   localparam logic [4:0] EXC_TR   = 5'h0d;
   // eret is not a real ExcCode; this value only tags the return sequence internally
   localparam logic [4:0] EXC_ERET = 5'h1f;

   localparam logic [4:0] CP0_REG_STATUS = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_REG_EPC    = 5'd14;

   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;

   // flag vector, highest priority in the MSB: {int, adel, ades, sys, ri, ov, tr, eret}
   localparam int NFLAGS = 8;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_W_STATUS = 2'd2,
      S_W_CAUSE  = 2'd3
   } state_t;

endpackage

// File: rtl/cp0_exc_ctrl_prio_enc.sv
// Fixed-priority encoder: exception flag vector in, {valid, excode} out.
module exc_prio_enc
   import cp0_exc_ctrl_pkg::*;
(
   input  logic [NFLAGS-1:0] flags_i,
   output logic              valid_o,
   output logic [4:0]        excode_o
);

   always_comb begin
      valid_o  = |flags_i;
      excode_o = EXC_INT;
      if      (flags_i[7]) excode_o = EXC_INT;
      else if (flags_i[6]) excode_o = EXC_ADEL;
      else if (flags_i[5]) excode_o = EXC_ADES;
      else if (flags_i[4]) excode_o = EXC_SYS;
      else if (flags_i[3]) excode_o = EXC_RI;
      else if (flags_i[2]) excode_o = EXC_OV;
      else if (flags_i[1]) excode_o = EXC_TR;
      else if (flags_i[0]) excode_o = EXC_ERET;
   end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: picks the exception, flushes/redirects, then writes EPC/Status/Cause.
// Optional CP0_EXC_BADVADDR_EN adds misaligned load/store detection (AdEL/AdES) and badvaddr_o.
//
// state      | meaning
// S_IDLE     | sampling MEM-stage flags, latching pc/code/bd on a hit
// S_FLUSH    | flush + redirect; EPC write unless eret or EXL already set
// S_W_STATUS | Status write (EXL=1 on entry, EXL=0 on eret)
// S_W_CAUSE  | Cause write with BD and ExcCode, then back to idle
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter int          IP_WIDTH   = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [4:0]  mem_exc_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_ds_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
`ifdef CP0_EXC_BADVADDR_EN
   input  logic [31:0] mem_addr_i,
   input  logic        mem_ld_i,
   input  logic        mem_st_i,
   output logic [31:0] badvaddr_o,
`endif
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_data_o,
   output logic        cp0_exc_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        stall_req_o,
   output logic [4:0]  excode_o
);

   state_t r_state, w_next;
   logic [31:0] r_epc;
   logic [4:0]  r_code;
   logic        r_bd, r_eret, r_skip_epc;

   logic [31:0] w_status_eff, w_cause_eff, w_epc_eff, w_status_wr;
   logic        w_int, w_adel, w_ades, w_valid, w_take, w_is_eret;
   logic [4:0]  w_code;
   logic [NFLAGS-1:0] w_flags;

   always_comb begin
      w_status_eff = status_i;
      w_cause_eff  = cause_i;
      w_epc_eff    = epc_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS) w_status_eff = wb_cp0_data_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_CAUSE)  w_cause_eff[9:8] = wb_cp0_data_i[9:8];
      if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_EPC)    w_epc_eff = wb_cp0_data_i;
   end

   assign w_int = (|(w_cause_eff[8 +: IP_WIDTH] & w_status_eff[8 +: IP_WIDTH]))
                  & w_status_eff[STATUS_IE] & ~w_status_eff[STATUS_EXL] & mem_valid_i;

`ifdef CP0_EXC_BADVADDR_EN
   assign w_adel = mem_ld_i & (|mem_addr_i[1:0]);
   assign w_ades = mem_st_i & (|mem_addr_i[1:0]);
`else
   assign w_adel = 1'b0;
   assign w_ades = 1'b0;
`endif

   assign w_flags = {w_int, w_adel, w_ades, mem_exc_i[1], mem_exc_i[2],
                     mem_exc_i[3], mem_exc_i[4], mem_exc_i[0]} & {NFLAGS{mem_valid_i}};

   exc_prio_enc u_prio (
      .flags_i  (w_flags),
      .valid_o  (w_valid),
      .excode_o (w_code)
   );

   assign w_take    = (r_state == S_IDLE) && w_valid;
   assign w_is_eret = (w_code == EXC_ERET);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_epc      <= '0;
         r_code     <= '0;
         r_bd       <= 1'b0;
         r_eret     <= 1'b0;
         r_skip_epc <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_code     <= w_code;
            r_bd       <= mem_in_ds_i;
            r_eret     <= w_is_eret;
            r_skip_epc <= w_status_eff[STATUS_EXL];
            // r_epc doubles as the eret return target
            r_epc      <= w_is_eret ? w_epc_eff : (mem_in_ds_i ? mem_pc_i - 32'd4 : mem_pc_i);
         end
      end
   end

`ifdef CP0_EXC_BADVADDR_EN
   logic [31:0] r_badvaddr;
   always_ff @(posedge clk) begin
      if (rst)                           r_badvaddr <= '0;
      else if (w_take && (w_code == EXC_ADEL || w_code == EXC_ADES)) r_badvaddr <= mem_addr_i;
   end
   assign badvaddr_o = r_badvaddr;
`endif

   always_comb begin
      w_status_wr             = w_status_eff;
      w_status_wr[STATUS_EXL] = ~r_eret;
   end

   always_comb begin
      w_next      = r_state;
      cp0_we_o    = 1'b0;
      cp0_waddr_o = '0;
      cp0_data_o  = '0;
      cp0_exc_o   = 1'b0;
      flush_o     = 1'b0;
      new_pc_o    = '0;
      stall_req_o = 1'b0;
      case (r_state)
         S_IDLE: if (w_valid) w_next = S_FLUSH;
         S_FLUSH: begin
            flush_o     = 1'b1;
            stall_req_o = 1'b1;
            new_pc_o    = r_eret ? r_epc : EXC_VECTOR;
            if (!r_eret && !r_skip_epc) begin
               cp0_we_o    = 1'b1;
               cp0_waddr_o = CP0_REG_EPC;
               cp0_data_o  = r_epc;
               cp0_exc_o   = 1'b1;
            end
            w_next = S_W_STATUS;
         end
         S_W_STATUS: begin
            stall_req_o = 1'b1;
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_REG_STATUS;
            cp0_data_o  = w_status_wr;
            cp0_exc_o   = ~r_eret;
            w_next      = r_eret ? S_IDLE : S_W_CAUSE;
         end
         S_W_CAUSE: begin
            stall_req_o = 1'b1;
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_REG_CAUSE;
            cp0_data_o  = {r_bd, w_cause_eff[30:7], r_code, w_cause_eff[1:0]};
            cp0_exc_o   = 1'b1;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign excode_o = r_code;

endmodule
